// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding, default frame
// geometry and the idle level of the serial line.
`timescale 1ns/1ps
package uart_rx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned DATA_BITS_DEF    = 8;
    localparam logic        LINE_IDLE        = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // Last count of the half-bit wait that lands on the start-bit centre.
    function automatic int unsigned half_bit_last(input int unsigned cpb);
        return (cpb / 32'd2) - 32'd1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs, with a
// configurable reset level so an idle-high line does not look active.
`timescale 1ns/1ps
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: oversamples the synchronized line, samples each
// bit at its centre and emits the byte with a one-cycle valid or error strobe.
`timescale 1ns/1ps
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [0:DATA_BITS-1] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [0:DATA_BITS-1] shift_q;
    logic [0:DATA_BITS-1] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 busy_q;

    uart_rx_sync #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Receive state machine; strobes default low and are raised for one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_s != LINE_IDLE) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (rx_s == LINE_IDLE) begin
                            // Line came back high before the centre: treat as noise.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q             <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s == LINE_IDLE) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line is a break, not a new start bit.
                    if (rx_s == LINE_IDLE) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx: drives serial frames at nominal and skewed
// rates and compares received bytes against a line-level frame model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam real BIT_NS = 160.0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [0:7] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [0:7] got_q[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         first_valid_cyc = -1;
    logic [0:7] last_good = '0;

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            got_q.push_back(rx_data);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Line order of byte b is b[0] first; rx_data[k] must equal line bit k.
    function automatic logic [0:7] line_vec(input logic [7:0] b);
        logic [0:7] v;
        for (int k = 0; k < 8; k++) v[k] = b[k];
        return v;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic align;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 || rx_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: valid=%b err=%b busy=%b data=%h, required 0 0 0 00",
                         i, rx_valid, frame_err, busy, rx_data);
            end
            rx = ~rx;
        end
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b pulses=%0d, required 0 0", busy, got_q.size());
        end
    endtask

    task automatic test_single_frame;
        int c0;
        got_q.delete();
        first_valid_cyc = -1;
        align();
        c0 = cyc;
        send_frame(8'hA5, 1'b1, BIT_NS);
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d pulses, required 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== line_vec(8'hA5)) begin
                errors++;
                $display("FAIL single_data: got %b, required %b", got_q[0], line_vec(8'hA5));
            end
            last_good = line_vec(8'hA5);
            checks++;
            if (first_valid_cyc - c0 < 153 || first_valid_cyc - c0 > 155) begin
                errors++;
                $display("FAIL single_latency: got %0d cycles, required 154+-1", first_valid_cyc - c0);
            end
        end
        checks++;
        if (ferr_cnt != 0) begin
            errors++;
            $display("FAIL single_no_ferr: got %0d, required 0", ferr_cnt);
        end
    endtask

    task automatic test_start_glitch;
        int ferr0;
        bit saw_busy;
        got_q.delete();
        ferr0 = ferr_cnt;
        saw_busy = 1'b0;
        align();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #2 rx = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        checks++;
        if (saw_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_seen: got %b, required 1", saw_busy);
        end
        checks++;
        if (busy !== 1'b0 || got_q.size() != 0 || ferr_cnt != ferr0) begin
            errors++;
            $display("FAIL glitch_no_output: busy=%b pulses=%0d ferr=%0d, required 0 0 0",
                     busy, got_q.size(), ferr_cnt - ferr0);
        end
    endtask

    task automatic test_frame_error;
        int ferr0;
        logic [7:0] b;
        got_q.delete();
        ferr0 = ferr_cnt;
        b = 8'($urandom);
        align();
        send_frame(b, 1'b0, BIT_NS);
        repeat (40) @(negedge clk);
        checks++;
        if (ferr_cnt != ferr0 + 1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL ferr_pulse: ferr=%0d pulses=%0d, required 1 0", ferr_cnt - ferr0, got_q.size());
        end
        checks++;
        if (rx_data !== last_good || busy !== 1'b1) begin
            errors++;
            $display("FAIL ferr_hold: data=%b busy=%b, required %b 1", rx_data, busy, last_good);
        end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_release: busy=%b, required 0", busy);
        end
        align();
        send_frame(8'h3C, 1'b1, BIT_NS);
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== line_vec(8'h3C) || ferr_cnt != ferr0 + 1) begin
            errors++;
            $display("FAIL ferr_recover: pulses=%0d data=%b ferr=%0d, required 1 %b 1",
                     got_q.size(), rx_data, ferr_cnt - ferr0, line_vec(8'h3C));
        end
        last_good = line_vec(8'h3C);
    endtask

    task automatic test_back_to_back;
        int ferr0;
        got_q.delete();
        ferr0 = ferr_cnt;
        align();
        send_frame(8'h00, 1'b1, BIT_NS / 1.03);
        send_frame(8'hFF, 1'b1, BIT_NS / 1.03);
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses, required 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== line_vec(8'h00) || got_q[1] !== line_vec(8'hFF)) begin
                errors++;
                $display("FAIL b2b_data: got %b %b, required 00000000 11111111", got_q[0], got_q[1]);
            end
            last_good = line_vec(8'hFF);
        end
        checks++;
        if (ferr_cnt != ferr0) begin
            errors++;
            $display("FAIL b2b_no_ferr: got %0d, required 0", ferr_cnt - ferr0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int ferr0;
        logic [7:0] b;
        got_q.delete();
        ferr0 = ferr_cnt;
        b = 8'h5A;
        align();
        rx = 1'b0;
        #(BIT_NS);
        for (int k = 0; k < 4; k++) begin
            rx = b[k];
            #(BIT_NS);
        end
        rx = b[4];
        #(BIT_NS / 2.0);
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_good = '0;
        repeat (40) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || ferr_cnt != ferr0 || busy !== 1'b0 || rx_data !== last_good) begin
            errors++;
            $display("FAIL midreset_abort: pulses=%0d ferr=%0d busy=%b data=%b, required 0 0 0 00000000",
                     got_q.size(), ferr_cnt - ferr0, busy, rx_data);
        end
        align();
        send_frame(8'h81, 1'b1, BIT_NS);
        repeat (4) @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== line_vec(8'h81)) begin
            errors++;
            $display("FAIL midreset_recover: pulses=%0d data=%b, required 1 %b",
                     got_q.size(), rx_data, line_vec(8'h81));
        end
        last_good = line_vec(8'h81);
    endtask

    task automatic test_random;
        logic [0:7] exp_q[$];
        int         exp_ferr;
        int         ferr0;
        logic [7:0] b;
        logic       bad;
        real        bit_ns;
        got_q.delete();
        ferr0 = ferr_cnt;
        exp_ferr = 0;
        for (int f = 0; f < 16; f++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            bit_ns = BIT_NS * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
            send_frame(b, ~bad, bit_ns);
            if (bad) begin
                exp_ferr++;
                repeat (20) @(posedge clk);
                rx = 1'b1;
                repeat ($urandom_range(3, 30)) @(posedge clk);
            end else begin
                exp_q.push_back(line_vec(b));
                last_good = line_vec(b);
                repeat ($urandom_range(0, 30)) @(posedge clk);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size() || ferr_cnt - ferr0 != exp_ferr) begin
            errors++;
            $display("FAIL random_counts: pulses=%0d ferr=%0d, required %0d %0d",
                     got_q.size(), ferr_cnt - ferr0, exp_q.size(), exp_ferr);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_data[%0d]: got %b, required %b", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rx_data !== last_good) begin
            errors++;
            $display("FAIL random_last: got %b, required %b", rx_data, last_good);
        end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL valid_err_exclusive: got %0d overlaps, required 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_start_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
